seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Sequential unsigned shift-and-add multiplier for the femtoRV32 datapath. It accepts two N-bit operands on a start strobe and iterates one partial product per clock. Each iteration feeds the accumulator high half and the multiplicand into an N-bit ripple-carry adder and consumes the adder's sum and carry-out. It returns a 2N-bit product with a one-cycle done pulse, and sits between operand decode and the writeback mux.

## Interface
- `N`, default 8: operand width; product is 2N bits.
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request; sampled only in IDLE.
- `multiplicand`, input, N: operand M; captured on accepted start.
- `multiplier`, input, N: operand Q; captured on accepted start.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: high for exactly one cycle in DONE.
- `product`, output, 2N: result register; updated only on entry to DONE and held otherwise.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: when `start`=1 at an edge:
  - capture M; load Q ← `multiplier`; clear A (N bits) and carry C; clear `cnt` (width $clog2(N)+1); go to RUN.
- RUN, each edge:
  - if Q[0]=1, {C,A} ← A + M from the adder; otherwise {C,A} ← {0,A}.
  - then shift {C,A,Q} right one bit: new A = {C, sum[N-1:1]}, new Q = {sum[0], Q[N-1:1]}.
  - `cnt` increments.
  - after the N-th iteration (`cnt`==N-1 at that edge): load `product` ← {A,Q} post-shift; go to DONE.
- DONE: `done`=1; next edge returns to IDLE unconditionally.
- `start` in RUN or DONE is ignored: no restart, no operand recapture.
- Operands may change after acceptance without effect.
- Arithmetic is unsigned only. The adder carry-out is never lost; the 2N-bit product is always exact.

## Timing
- Reset (async, `rst_n`=0): state=IDLE, `busy`=0, `done`=0, `product`=0, `cnt`=0, A/Q/M/C=0.
- Reset release takes effect at the next edge; no outputs glitch while `rst_n` is low.
- Latency:
  - start accepted at edge E0.
  - `busy` is high from after E0 through edge E0+N.
  - `done` is high and `product` valid in the cycle after edge E0+N.
  - Total N+1 edges from acceptance to `done`.
- Throughput: one operation per N+2 cycles. The earliest next acceptance is the edge after DONE, i.e. IDLE with `start` high.
- `done` and `busy` are never high simultaneously.
- Reset mid-RUN aborts the operation: no `done` pulse, and `product` returns to 0.
- `product` is stable from DONE until the next completed operation, including while a later operation is in RUN.

## Structure
- Shared package `mul_pkg`:
  - state encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - default width constant `MUL_N`=8.
- One sub-module: the N-bit ripple-carry adder `RCA` (parameter n=N), with A=accumulator high half, B=M, outputs sum and Cout.
- Carry-in is tied to 0 inside the adder. No other adder logic lives in this block.
- Everything else (FSM, counter, shift registers, product register) is flat in `seq_multiplier`.

## Test plan
- Reset, then N=8, start with M=13, Q=11 → `busy` for 8 cycles, then `done` pulse with `product`=16'h008F; `product` still 16'h008F 5 cycles later.
- M=255, Q=255 → `product`=16'hFE01, which exercises the adder carry-out every iteration; also run M=0, Q=200 → 16'h0000 and M=1, Q=255 → 16'h00FF.
- Start with M=7, Q=9 held high continuously → results 16'h003F; second acceptance only at IDLE, with `done` pulses spaced exactly 10 cycles apart.
- During RUN, pulse `start` with M=2, Q=2 and toggle operand inputs → ignored; result still 16'h003F for the original M=7, Q=9.
- Assert `rst_n`=0 at iteration 4 of M=200, Q=100 → outputs immediately 0, no `done`. After release, M=200, Q=100 → 16'h4E20.
- Randomised sweep of 1000 operand pairs against a reference multiply; check `done` width is 1 and `busy`/`done` are mutually exclusive every cycle.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier.
// State encoding and default operand width.
package mul_pkg;

    localparam int MUL_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/RCA.sv
// N-bit ripple-carry adder, carry-in tied low.
// Used by seq_multiplier for each partial-product add.
module RCA #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] sum,
    output logic         cout
);

    logic [n:0] c;

    always_comb begin
        c[0] = 1'b0;
        sum  = '0;
        for (int i = 0; i < n; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[n];
    end

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier, one partial product per clock.
// Returns a 2N-bit product with a single-cycle done pulse.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int N = MUL_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N) + 1;

    state_t        state;
    logic [N-1:0]  m;
    logic [N-1:0]  a;
    logic [N-1:0]  q;
    logic [CW-1:0] cnt;

    logic [N-1:0]  sum;
    logic          cout;
    logic [N-1:0]  acc;
    logic          cy;
    logic [N-1:0]  a_nx;
    logic [N-1:0]  q_nx;

    RCA #(.n(N)) u_rca (
        .a    (a),
        .b    (m),
        .sum  (sum),
        .cout (cout)
    );

    // The carry shifts straight into the top of A, so it never needs storing.
    always_comb begin
        acc  = q[0] ? sum : a;
        cy   = q[0] & cout;
        a_nx = {cy, acc[N-1:1]};
        q_nx = {acc[0], q[N-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            m       <= '0;
            a       <= '0;
            q       <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m     <= multiplicand;
                        q     <= multiplier;
                        a     <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a   <= a_nx;
                    q   <= q_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        product <= {a_nx, q_nx};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (N=8).
// Table vectors, corner sequences and a random sweep vs M*Q.
module tb_seq_multiplier;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  multiplicand;
    logic [N-1:0]  multiplier;
    logic          busy;
    logic          done;
    logic [2*N-1:0] product;

    int total = 0;
    int bad   = 0;
    int excl_err  = 0;
    int width_err = 0;
    logic prev_done = 1'b0;

    seq_multiplier #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && done) excl_err <= excl_err + 1;
            if (done && prev_done) width_err <= width_err + 1;
        end
        prev_done <= done;
    end

    typedef struct {
        logic [N-1:0]   m;
        logic [N-1:0]   q;
        logic [2*N-1:0] exp;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one operation; returns product at done and busy-cycle count.
    task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q,
                          output logic [2*N-1:0] p, output int bc,
                          output bit ok);
        @(negedge clk);
        start = 1'b1;
        multiplicand = m;
        multiplier = q;
        @(negedge clk);
        start = 1'b0;
        multiplicand = $urandom;
        multiplier = $urandom;
        bc = 0;
        ok = 1'b0;
        p = '0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ok = 1'b1;
                p = product;
                break;
            end
            if (busy) bc++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [2*N-1:0] p;
        int bc;
        bit ok;
        int cyc;
        int d0, d1, nd;
        int seen;

        tbl[0] = '{8'd13,  8'd11,  16'h008F};
        tbl[1] = '{8'd255, 8'd255, 16'hFE01};
        tbl[2] = '{8'd0,   8'd200, 16'h0000};
        tbl[3] = '{8'd1,   8'd255, 16'h00FF};
        tbl[4] = '{8'd7,   8'd9,   16'h003F};
        tbl[5] = '{8'd200, 8'd100, 16'h4E20};

        rst_n = 1'b0;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_product", {16'd0, product}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(8'd13, 8'd11, p, bc, ok);
        check("first_ok", {31'd0, ok}, 1);
        check("first_busy_cycles", bc, N);
        check("first_product", {16'd0, p}, 16'h008F);
        repeat (5) @(negedge clk);
        check("hold_product", {16'd0, product}, 16'h008F);

        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].m, tbl[i].q, p, bc, ok);
            check($sformatf("tbl%0d_ok", i), {31'd0, ok}, 1);
            check($sformatf("tbl%0d_busy", i), bc, N);
            check($sformatf("tbl%0d_prod", i), {16'd0, p}, {16'd0, tbl[i].exp});
        end

        run_op(8'd1, 8'd255, p, bc, ok);
        check("pre_ign_prod", {16'd0, p}, 16'h00FF);

        // start pulses and operand changes mid-RUN must be ignored
        @(negedge clk);
        start = 1'b1;
        multiplicand = 8'd7;
        multiplier = 8'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        multiplicand = 8'd2;
        multiplier = 8'd2;
        @(negedge clk);
        start = 1'b0;
        multiplicand = 8'hA5;
        multiplier = 8'h5A;
        @(negedge clk);
        multiplicand = 8'h3C;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ign_ok", {31'd0, ok}, 1);
        check("ign_prod", {16'd0, product}, 16'h003F);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        check("ign_no_restart", seen, 0);

        // start held high: back-to-back operations
        start = 1'b1;
        multiplicand = 8'd7;
        multiplier = 8'd9;
        d0 = -1;
        d1 = -1;
        nd = 0;
        for (cyc = 0; cyc < 26; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (nd == 0) d0 = cyc;
                else if (nd == 1) d1 = cyc;
                nd++;
                check($sformatf("cont_prod%0d", nd), {16'd0, product}, 16'h003F);
            end
        end
        start = 1'b0;
        check("cont_two_dones", {31'd0, (nd >= 2)}, 1);
        check("cont_spacing", d1 - d0, N + 2);
        repeat (12) @(negedge clk);

        // reset mid-RUN
        @(negedge clk);
        start = 1'b1;
        multiplicand = 8'd200;
        multiplier = 8'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy_pre", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_done", {31'd0, done}, 0);
        check("mid_rst_prod", {16'd0, product}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("mid_no_done", seen, 0);
        run_op(8'd200, 8'd100, p, bc, ok);
        check("post_rst_ok", {31'd0, ok}, 1);
        check("post_rst_prod", {16'd0, p}, 16'h4E20);

        for (int i = 0; i < 1000; i++) begin
            logic [N-1:0] rm, rq;
            logic [2*N-1:0] ref_p;
            rm = N'($urandom);
            rq = N'($urandom);
            ref_p = (2*N)'(rm) * (2*N)'(rq);
            run_op(rm, rq, p, bc, ok);
            if (!ok || p !== ref_p || bc != N)
                check($sformatf("rand_%0h_%0h", rm, rq),
                      {8'd0, ok, 7'd0, p}, {8'd0, 1'b1, 7'd0, ref_p});
            else
                total++;
        end

        check("busy_done_excl", excl_err, 0);
        check("done_width", width_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
